io_controller: RTL
==================

IO_CONTROLLER -- requirements
Module: io_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: memory address width.
REQ-002 SHALL have parameter RES_BASE, default 512: base address of the result region in memory.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port intrpt, input, 1: feeder command strobe, level-sensitive.
REQ-006 SHALL have port cmd, input, 1: load = 1, process = 0.
REQ-007 SHALL have port done, output, 1: one-cycle acknowledge or result-valid strobe.
REQ-008 SHALL have port data_in, input, 32: data bus value driven by the feeder.
REQ-009 SHALL have port data_out, output, 32: result or header word.
REQ-010 SHALL have port data_oe, output, 1: enable for the controller's data bus drive.
REQ-011 SHALL have ports mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, 32) and mem_rdata (input, 32): memory port with 1-cycle read latency.
REQ-012 SHALL have ports solver_start (output, 1) and solver_done (input, 1): solver pulse handshake.
REQ-013 SHALL have port err, output, 1: sticky load-overflow flag.

Function
REQ-014 SHALL implement states IDLE, LOAD, ACK, WAIT_LOW, START, RUN, HDR, RD, STREAM, SEP and FINISH.
REQ-015 In IDLE, intrpt=1 with cmd=1 SHALL go to LOAD; intrpt=1 with cmd=0 SHALL go to START.
REQ-016 The first load after reset SHALL be the header word: T = data_in[3:0], N = data_in[9:4], and the header SHALL NOT be written to memory.
REQ-017 Every later load SHALL write data_in to mem_addr = load count (starting at 0), with mem_we high for exactly one cycle.
REQ-018 ACK SHALL drive done=1 for one cycle, then go to WAIT_LOW.
REQ-019 In WAIT_LOW, intrpt=0 SHALL go to IDLE; intrpt=1 with cmd=0 SHALL go directly to START, because the last packet is never followed by intrpt low.
REQ-020 A load when the load count equals RES_BASE SHALL NOT be written, SHALL set err=1, and SHALL still be acknowledged.
REQ-021 START SHALL pulse solver_start for one cycle, then go to RUN.
REQ-022 RUN SHALL wait for solver_done=1, then go to HDR.
REQ-023 HDR SHALL drive data_out = {22'b0, N, T}, data_oe=1 and done=1 for one cycle.
REQ-024 The element count SHALL be T*N as an unsigned 10-bit product.
REQ-025 If T*N = 0, HDR SHALL go to FINISH; otherwise it SHALL go to RD.
REQ-026 RD SHALL issue a read at RES_BASE + element index; STREAM SHALL present mem_rdata on data_out with done=1 and data_oe=1 for one cycle.
REQ-027 Each result word SHALL take exactly 2 cycles (RD then STREAM), so there is a 1-cycle gap between done pulses.
REQ-028 After the last element, the controller SHALL go to FINISH.
REQ-029 FINISH SHALL hold data_oe=0 and done=0 and ignore intrpt until reset.
REQ-030 intrpt SHALL be ignored in START, RUN, HDR, RD, STREAM and SEP.
REQ-031 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-032 data_oe SHALL be 1 only in HDR, STREAM and SEP.

Reset
REQ-033 With reset=0 at a clock edge, the state SHALL become IDLE.
REQ-034 On that edge, done, data_oe, mem_we, solver_start and err SHALL become 0, and data_out, mem_addr, mem_wdata, the load count, the element index, N and T SHALL become 0.
REQ-035 The header-pending flag SHALL be set on reset.
REQ-036 Reset SHALL take effect from any state, including mid-stream, and any partial stream SHALL be abandoned.

Configuration
REQ-037 With ROW_SEP_EN defined, after every N streamed elements except the last row, SEP SHALL emit one done pulse with data_out = 32'hFFFFFFFF and data_oe=1, and the element index SHALL NOT advance.
REQ-038 With ROW_SEP_EN undefined, the SEP state SHALL be unreachable and elements SHALL stream back-to-back.

Verification
REQ-039 Load header 0x00000032 (T=2, N=3), then 6 words, then process -> 6 mem writes at addresses 0..5, 6 done acks, one solver_start pulse.
REQ-040 Same run, solver_done after 20 cycles, memory RES_BASE..+5 = 1..6 -> header 0x32, then words 1..6 with done spaced 2 cycles apart.
REQ-041 ROW_SEP_EN defined, same run -> 1,2,3,FFFFFFFF,4,5,6.
REQ-042 intrpt held at 1 with cmd changed from 1 to 0 right after the last ack -> START with no intermediate IDLE.
REQ-043 Header with T=0 -> header word only, then FINISH, and no memory reads.
REQ-044 Reset asserted during STREAM on element 3 -> IDLE the next cycle with all outputs 0, and the next load is treated as the header.

Source files
------------

// File: rtl/io_controller.sv
// io_controller: loads a header and data words into memory, kicks a solver, then streams the result region back
// Ports:
//   clk, reset (sync, active-low)           clock and reset
//   intrpt, cmd, data_in                    feeder command strobe (cmd 1 = load, 0 = process) and data
//   done, data_out, data_oe                 acknowledge / result strobe, result or header word, bus drive enable
//   mem_we, mem_addr, mem_wdata, mem_rdata  memory port, 1-cycle read latency
//   solver_start, solver_done               solver pulse handshake
//   err                                     sticky load-overflow flag
// Optional: define ROW_SEP_EN to insert an all-ones separator word after every row of N elements except the last.
module io_controller #(
  parameter int ADDR_W   = 10,
  parameter int RES_BASE = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              intrpt,
  input  logic              cmd,
  output logic              done,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              data_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              solver_start,
  input  logic              solver_done,
  output logic              err
);
  typedef enum logic [3:0] {IDLE, LOAD, ACK, WAIT_LOW, START, RUN, HDR, RD, STREAM, SEP, FINISH} state_t;
  localparam logic [ADDR_W-1:0] RES_A = ADDR_W'(RES_BASE);
  state_t state_q;
  logic done_q, oe_q, we_q, start_q, err_q, hdr_q;
  logic [31:0] dout_q, wdata_q;
  logic [ADDR_W-1:0] addr_q, ld_cnt_q;
  logic [9:0] idx_q, idx_d, elems;
  logic [5:0] n_q;
  logic [3:0] t_q;
`ifdef ROW_SEP_EN
  logic [5:0] col_q;
`endif
  always_comb begin
    idx_d = idx_q + 10'd1;
    elems = 10'(t_q) * 10'(n_q);
  end
  // The read issued in RD returns during STREAM, so the word is forwarded straight from the memory port.
  assign data_out     = (state_q == STREAM) ? mem_rdata : dout_q;
  assign done         = done_q;
  assign data_oe      = oe_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign solver_start = start_q;
  assign err          = err_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      hdr_q    <= 1'b1;
      dout_q   <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      ld_cnt_q <= '0;
      idx_q    <= '0;
      n_q      <= '0;
      t_q      <= '0;
`ifdef ROW_SEP_EN
      col_q    <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (intrpt && cmd) state_q <= LOAD;
          else if (intrpt) begin
            state_q <= START;
            start_q <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= ACK;
          done_q  <= 1'b1;
          if (hdr_q) begin
            t_q   <= data_in[3:0];
            n_q   <= data_in[9:4];
            hdr_q <= 1'b0;
          end else if (ld_cnt_q == RES_A) err_q <= 1'b1;
          else begin
            we_q     <= 1'b1;
            addr_q   <= ld_cnt_q;
            wdata_q  <= data_in;
            ld_cnt_q <= ld_cnt_q + ADDR_W'(1);
          end
        end
        ACK: state_q <= WAIT_LOW;
        // The final load is followed directly by a process command without intrpt dropping.
        WAIT_LOW: begin
          if (!intrpt) state_q <= IDLE;
          else if (!cmd) begin
            state_q <= START;
            start_q <= 1'b1;
          end
        end
        START: state_q <= RUN;
        RUN: begin
          if (solver_done) begin
            state_q <= HDR;
            done_q  <= 1'b1;
            oe_q    <= 1'b1;
            dout_q  <= {22'b0, n_q, t_q};
          end
        end
        HDR: begin
          if (elems == '0) state_q <= FINISH;
          else begin
            state_q <= RD;
            addr_q  <= RES_A + ADDR_W'(idx_q);
          end
        end
        RD: begin
          state_q <= STREAM;
          done_q  <= 1'b1;
          oe_q    <= 1'b1;
        end
        STREAM: begin
          idx_q <= idx_d;
          if (idx_d == elems) state_q <= FINISH;
`ifdef ROW_SEP_EN
          else if (col_q + 6'd1 == n_q) begin
            state_q <= SEP;
            col_q   <= '0;
            done_q  <= 1'b1;
            oe_q    <= 1'b1;
            dout_q  <= '1;
          end
`endif
          else begin
            state_q <= RD;
            addr_q  <= RES_A + ADDR_W'(idx_d);
`ifdef ROW_SEP_EN
            col_q   <= col_q + 6'd1;
`endif
          end
        end
        SEP: begin
          state_q <= RD;
          addr_q  <= RES_A + ADDR_W'(idx_q);
        end
        FINISH: state_q <= FINISH;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
